// File: rtl/core_pkg.sv
// Shared constants for the PC generator slice: select bits,
// handler FSM encoding and default vector addresses.
package core_pkg;

  localparam int SEL_BR = 2;
  localparam int SEL_JR = 1;
  localparam int SEL_J  = 0;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HANDLER = 1'b1
  } exc_state_e;

  localparam logic [31:0] DEF_EXC_BASE = 32'h0000_0100;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_mux.sv
// Priority select of the next fetch PC: exception, eret,
// ID redirects, then sequential; stall holds normal flow.
import core_pkg::*;

module pc_next_mux #(
  parameter int              AW       = 32,
  parameter logic [AW-1:0]   EXC_BASE = AW'(DEF_EXC_BASE)
) (
  input  logic [AW-1:0] pc_i,
  input  logic [AW-1:0] pc_plus_inc_i,
  input  logic [AW-1:0] epc_i,
  input  logic [AW-1:0] br_addr_i,
  input  logic [AW-1:0] jr_addr_i,
  input  logic [AW-1:0] j_addr_i,
  input  logic [2:0]    sel_i,
  input  logic          stall_i,
  input  logic          exc_i,
  input  logic          eret_take_i,
  output logic [AW-1:0] pc_nxt_o
);

  always_comb begin
    pc_nxt_o = pc_i;
    priority case (1'b1)
      exc_i:         pc_nxt_o = EXC_BASE;
      eret_take_i:   pc_nxt_o = epc_i;
      stall_i:       pc_nxt_o = pc_i;
      sel_i[SEL_BR]: pc_nxt_o = br_addr_i;
      sel_i[SEL_JR]: pc_nxt_o = jr_addr_i;
      sel_i[SEL_J]:  pc_nxt_o = j_addr_i;
      default:       pc_nxt_o = pc_plus_inc_i;
    endcase
  end

endmodule

// File: rtl/pc_gen_exc.sv
// Fetch PC generator with precise exception entry, EPC,
// eret return, flush pulse and sticky double-fault flag.
import core_pkg::*;

module pc_gen_exc #(
  parameter int            AW       = 32,
  parameter int            PC_INC   = 1,
  parameter logic [AW-1:0] RESET_PC = AW'(DEF_RESET_PC),
  parameter logic [AW-1:0] EXC_BASE = AW'(DEF_EXC_BASE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] beq_bne_addr_id,
  input  logic [AW-1:0] jr_addr_id,
  input  logic [AW-1:0] jal_j_addr_id,
  input  logic [2:0]    npc_mux_sel,
  input  logic          stall_pc,
  input  logic          exc_req,
  input  logic [AW-1:0] exc_pc,
  input  logic          eret,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_plus_inc,
  output logic [AW-1:0] epc,
  output logic          in_exc,
  output logic          flush,
  output logic          dbl_fault
);

  exc_state_e    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] epc_q, epc_d;
  logic          flush_q, flush_d;
  logic          dbl_q, dbl_d;
  logic          eret_take;

  assign pc_plus_inc = pc_q + AW'(PC_INC);

  pc_next_mux #(
    .AW       (AW),
    .EXC_BASE (EXC_BASE)
  ) u_mux (
    .pc_i          (pc_q),
    .pc_plus_inc_i (pc_plus_inc),
    .epc_i         (epc_q),
    .br_addr_i     (beq_bne_addr_id),
    .jr_addr_i     (jr_addr_id),
    .j_addr_i      (jal_j_addr_id),
    .sel_i         (npc_mux_sel),
    .stall_i       (stall_pc),
    .exc_i         (exc_req),
    .eret_take_i   (eret_take),
    .pc_nxt_o      (pc_d)
  );

  always_comb begin
    state_d   = state_q;
    epc_d     = epc_q;
    flush_d   = 1'b0;
    dbl_d     = dbl_q;
    eret_take = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (exc_req) begin
          epc_d   = exc_pc;
          flush_d = 1'b1;
          state_d = ST_HANDLER;
        end
      end
      ST_HANDLER: begin
        if (exc_req) begin
          flush_d = 1'b1;
          dbl_d   = 1'b1;
        end else if (eret && !stall_pc) begin
          eret_take = 1'b1;
          flush_d   = 1'b1;
          state_d   = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      flush_q <= 1'b0;
      dbl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      flush_q <= flush_d;
      dbl_q   <= dbl_d;
    end
  end

  assign pc        = pc_q;
  assign epc       = epc_q;
  assign in_exc    = (state_q == ST_HANDLER);
  assign flush     = flush_q;
  assign dbl_fault = dbl_q;

endmodule
